// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-port ALU share arbiter.
// Covers ALU opcodes, FSM state encoding and response-flag bit positions.
package alu_arb_pkg;

   localparam int ALU_WIDTH   = 32;
   localparam int ALU_OPC_W   = 5;
   localparam int ALU_SHAMT_W = 5;
   localparam int FLAG_W      = 3;

   localparam logic [ALU_OPC_W-1:0] OP_ADD = 5'b00000;
   localparam logic [ALU_OPC_W-1:0] OP_SUB = 5'b00001;
   localparam logic [ALU_OPC_W-1:0] OP_AND = 5'b00010;
   localparam logic [ALU_OPC_W-1:0] OP_OR  = 5'b00011;
   localparam logic [ALU_OPC_W-1:0] OP_SLL = 5'b00100;
   localparam logic [ALU_OPC_W-1:0] OP_SRA = 5'b00101;

   // Flags travel as {overflow, isLessThan, isNotEqual}
   localparam int FLAG_NE = 0;
   localparam int FLAG_LT = 1;
   localparam int FLAG_OV = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin arbiter.
// The pointer is owned by the parent; this block only picks a winner.
module rr_arbiter_2 (
   input  logic [1:0] req,
   input  logic       ptr,
   input  logic       en,
   output logic [1:0] grant,
   output logic       winner
);

   // With a single requester it wins outright; on contention the pointer decides
   always_comb begin
      grant = 2'b00;
      if (en) begin
         if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
         else              grant = req;
      end
      winner = grant[1];
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters.
// One transaction in flight: grant in IDLE, one EXEC cycle, then hold the response in RESP.
module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter int WIDTH   = ALU_WIDTH,
   parameter int OPC_W   = ALU_OPC_W,
   parameter int SHAMT_W = ALU_SHAMT_W
) (
   input  logic               clock,
   input  logic               reset_n,

   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [WIDTH-1:0]   req0_operandA,
   input  logic [WIDTH-1:0]   req0_operandB,
   input  logic [OPC_W-1:0]   req0_opcode,
   input  logic [SHAMT_W-1:0] req0_shamt,

   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [WIDTH-1:0]   req1_operandA,
   input  logic [WIDTH-1:0]   req1_operandB,
   input  logic [OPC_W-1:0]   req1_opcode,
   input  logic [SHAMT_W-1:0] req1_shamt,

   output logic               resp0_valid,
   input  logic               resp0_ready,
   output logic               resp1_valid,
   input  logic               resp1_ready,
   output logic [WIDTH-1:0]   resp_result,
   output logic [FLAG_W-1:0]  resp_flags,

   output logic [WIDTH-1:0]   alu_operandA,
   output logic [WIDTH-1:0]   alu_operandB,
   output logic [OPC_W-1:0]   alu_opcode,
   output logic [SHAMT_W-1:0] alu_shamt,
   input  logic [WIDTH-1:0]   alu_result,
   input  logic [FLAG_W-1:0]  alu_flags
);

   arb_state_t state, next_state;
   logic       rr_ptr;
   logic       owner;
   logic [1:0] grant;
   logic       winner;
   logic       grant_any;
   logic       owner_resp_ready;

   rr_arbiter_2 u_arb (
      .req    ({req1_valid, req0_valid}),
      .ptr    (rr_ptr),
      .en     (state == IDLE),
      .grant  (grant),
      .winner (winner)
   );

   assign grant_any        = |grant;
   assign owner_resp_ready = owner ? resp1_ready : resp0_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state  = state;
      req0_ready  = grant[0];
      req1_ready  = grant[1];
      resp0_valid = 1'b0;
      resp1_valid = 1'b0;
      case (state)
         IDLE: if (grant_any) next_state = EXEC;
         EXEC: next_state = RESP;
         RESP: begin
            resp0_valid = !owner;
            resp1_valid = owner;
            if (owner_resp_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Operand registers stay put outside the grant so the ALU inputs never glitch
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         alu_operandA <= '0;
         alu_operandB <= '0;
         alu_opcode   <= '0;
         alu_shamt    <= '0;
         owner        <= 1'b0;
         rr_ptr       <= 1'b0;
         resp_result  <= '0;
         resp_flags   <= '0;
      end else begin
         if (state == IDLE && grant_any) begin
            alu_operandA <= winner ? req1_operandA : req0_operandA;
            alu_operandB <= winner ? req1_operandB : req0_operandB;
            alu_opcode   <= winner ? req1_opcode   : req0_opcode;
            alu_shamt    <= winner ? req1_shamt    : req0_shamt;
            owner        <= winner;
            rr_ptr       <= ~winner;
         end
         if (state == EXEC) begin
            resp_result <= alu_result;
            resp_flags  <= alu_flags;
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU attached.
// Steps through reset, single request, contention, stall, flags and back-to-back issue.
module tb_alu_share_arbiter;
   import alu_arb_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_operandA = '0, req0_operandB = '0;
   logic [31:0] req1_operandA = '0, req1_operandB = '0;
   logic [4:0]  req0_opcode = '0, req1_opcode = '0;
   logic [4:0]  req0_shamt = '0, req1_shamt = '0;
   logic        resp0_valid, resp1_valid;
   logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
   logic [31:0] resp_result;
   logic [2:0]  resp_flags;
   logic [31:0] alu_operandA, alu_operandB;
   logic [4:0]  alu_opcode, alu_shamt;
   logic [31:0] alu_result;
   logic [2:0]  alu_flags;

   int checks = 0;
   int errors = 0;
   int hs_cyc[$];

   always #5 clock = ~clock;

   alu_share_arbiter dut (
      .clock(clock), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_operandA(req0_operandA), .req0_operandB(req0_operandB),
      .req0_opcode(req0_opcode), .req0_shamt(req0_shamt),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_operandA(req1_operandA), .req1_operandB(req1_operandB),
      .req1_opcode(req1_opcode), .req1_shamt(req1_shamt),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp_result(resp_result), .resp_flags(resp_flags),
      .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
      .alu_opcode(alu_opcode), .alu_shamt(alu_shamt),
      .alu_result(alu_result), .alu_flags(alu_flags)
   );

   // Reference ALU standing in for the external execute unit
   always_comb begin
      alu_result = '0;
      alu_flags  = '0;
      case (alu_opcode)
         OP_ADD: begin
            alu_result = alu_operandA + alu_operandB;
            alu_flags[FLAG_OV] = (alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
         end
         OP_SUB: begin
            alu_result = alu_operandA - alu_operandB;
            alu_flags[FLAG_OV] = (alu_operandA[31] != alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
         end
         OP_AND: alu_result = alu_operandA & alu_operandB;
         OP_OR:  alu_result = alu_operandA | alu_operandB;
         OP_SLL: alu_result = alu_operandA << alu_shamt;
         OP_SRA: alu_result = $unsigned($signed(alu_operandA) >>> alu_shamt);
         default: alu_result = '0;
      endcase
      alu_flags[FLAG_LT] = $signed(alu_operandA) < $signed(alu_operandB);
      alu_flags[FLAG_NE] = alu_operandA != alu_operandB;
   end

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state
      #1;
      check_output("rst_req0_ready", req0_ready, 0);
      check_output("rst_req1_ready", req1_ready, 0);
      check_output("rst_resp0_valid", resp0_valid, 0);
      check_output("rst_resp1_valid", resp1_valid, 0);
      check_output("rst_alu_opA", alu_operandA, 0);
      check_output("rst_resp_result", resp_result, 0);
      check_output("rst_resp_flags", resp_flags, 0);
      repeat (2) tick();
      reset_n = 1'b1;

      // Single AND request on port 0
      req0_valid = 1'b1; req0_opcode = OP_AND;
      req0_operandA = 32'hF0F0_00FF; req0_operandB = 32'h0FF0_0F0F;
      #1;
      check_output("and_req0_ready", req0_ready, 1);
      check_output("and_req1_ready", req1_ready, 0);
      tick();
      #1;
      check_output("and_exec_ready", req0_ready, 0);
      check_output("and_exec_valid", resp0_valid, 0);
      check_output("and_alu_opA", alu_operandA, 32'hF0F0_00FF);
      check_output("and_alu_opc", alu_opcode, OP_AND);
      req0_valid = 1'b0;
      tick();
      check_output("and_resp0_valid", resp0_valid, 1);
      check_output("and_resp1_valid", resp1_valid, 0);
      check_output("and_result", resp_result, 32'h00F0_000F);
      resp0_ready = 1'b1;
      tick();
      resp0_ready = 1'b0;
      check_output("and_done_valid", resp0_valid, 0);

      // Reset during EXEC drops the transaction
      req1_valid = 1'b1; req1_opcode = OP_ADD;
      req1_operandA = 32'd5; req1_operandB = 32'd6;
      #1;
      check_output("rx_req1_ready", req1_ready, 1);
      tick();
      req1_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check_output("rx_resp1_valid", resp1_valid, 0);
      check_output("rx_alu_opA", alu_operandA, 0);
      check_output("rx_resp_result", resp_result, 0);
      tick();
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check_output("rx_no_resp", {resp1_valid, resp0_valid}, 0);
      end

      // Contention straight after reset: port 0 first
      req0_valid = 1'b1; req0_opcode = OP_ADD; req0_operandA = 32'd1; req0_operandB = 32'd2;
      req1_valid = 1'b1; req1_opcode = OP_OR;  req1_operandA = 32'hF0; req1_operandB = 32'h0F;
      #1;
      check_output("c1_grant", {req1_ready, req0_ready}, 2'b01);
      tick();
      req0_valid = 1'b0;
      #1;
      check_output("c1_exec_grant", {req1_ready, req0_ready}, 2'b00);
      tick();
      check_output("c1_resp0", {resp1_valid, resp0_valid}, 2'b01);
      check_output("c1_result", resp_result, 32'd3);
      resp0_ready = 1'b1;
      tick();
      resp0_ready = 1'b0;
      #1;
      check_output("c2_grant", {req1_ready, req0_ready}, 2'b10);
      tick();
      req1_valid = 1'b0;
      tick();
      check_output("c2_resp1", {resp1_valid, resp0_valid}, 2'b10);
      check_output("c2_result", resp_result, 32'h0000_00FF);

      // Stall port 1 response while port 0 waits
      req0_valid = 1'b1; req0_opcode = OP_SUB;
      req0_operandA = 32'h7FFF_FFFF; req0_operandB = 32'hFFFF_FFFF;
      req1_valid = 1'b1; req1_opcode = OP_SLL;
      req1_operandA = 32'd1; req1_operandB = 32'd0; req1_shamt = 5'd4;
      for (int c = 0; c < 10; c++) begin
         #1;
         check_output("stall_resp1_valid", resp1_valid, 1);
         check_output("stall_result", resp_result, 32'h0000_00FF);
         check_output("stall_req_ready", {req1_ready, req0_ready}, 2'b00);
         tick();
      end
      resp1_ready = 1'b1;
      #1;
      check_output("stall_rel_ready", req0_ready, 0);
      tick();
      resp1_ready = 1'b0;
      check_output("stall_idle_resp1", resp1_valid, 0);
      check_output("pair2_grant", {req1_ready, req0_ready}, 2'b01);
      tick();
      req0_valid = 1'b0;
      tick();
      check_output("sub_resp0", resp0_valid, 1);
      check_output("sub_result", resp_result, 32'h8000_0000);
      check_output("sub_flags", resp_flags, 3'b101);
      resp0_ready = 1'b1;
      tick();
      resp0_ready = 1'b0;
      check_output("sll_grant", {req1_ready, req0_ready}, 2'b10);
      tick();
      req1_valid = 1'b0;
      tick();
      check_output("sll_resp1", resp1_valid, 1);
      check_output("sll_result", resp_result, 32'h0000_0010);
      check_output("sll_flags", resp_flags, 3'b001);
      resp1_ready = 1'b1;
      tick();
      resp1_ready = 1'b0;

      // Back-to-back ADDs with response always accepted
      req0_valid = 1'b1; req0_opcode = OP_ADD; req0_operandA = 32'd10; req0_operandB = 32'd20;
      resp0_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (req0_ready) hs_cyc.push_back(c);
         if (resp0_valid) check_output("b2b_result", resp_result, 32'd30);
         tick();
      end
      req0_valid = 1'b0;
      resp0_ready = 1'b0;
      check_output("b2b_count", hs_cyc.size(), 4);
      for (int i = 1; i < hs_cyc.size(); i++)
         check_output("b2b_spacing", hs_cyc[i] - hs_cyc[i-1], 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
